mem_port_arbiter: RTL and testbench

Sequences and shares the processor's single unified memory port between the instruction-fetch requester and the data-memory requester. It sits between the datapath's fetch/load-store logic and the memory array, and turns each granted request into a fixed-length multi-cycle memory access. It arbitrates round-robin on conflict and returns read data with a one-cycle acknowledge pulse. The multicycle controller stalls `PCen`/`RFwr` on the requester's pending-ack condition.

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Round-robin on conflict; fixed-length access; one-cycle ack pulse.
module mem_port_arbiter #(
  parameter int WAIT = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

  state_t        state;
  state_t        state_nx;
  logic [3:0]    cnt;
  logic          own_dm;
  logic          last_dm;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          any_req;
  logic          pick_dm;
  logic          fin;

  assign any_req = if_req | dm_req;
  // DM wins when alone, or on conflict when IF was served last
  assign pick_dm = dm_req & (~if_req | ~last_dm);
  assign fin     = (state == ACCESS) && (cnt == 4'd0);

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory strobes decoded from registered state only
  always_comb begin
    mem_en = (state == ACCESS);
    mem_we = (state == ACCESS) & lat_we;
    busy   = (state != IDLE);
  end

  // Grant latches and access countdown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 4'd0;
      own_dm    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      own_dm    <= pick_dm;
      lat_we    <= pick_dm & dm_we;
      lat_addr  <= pick_dm ? dm_addr : if_addr;
      lat_wdata <= pick_dm ? dm_wdata : '0;
      cnt       <= CNT_INIT;
    end else if (state == ACCESS && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Completion: read capture, ack pulse, round-robin history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_ack   <= 1'b0;
      dm_ack   <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      last_dm  <= 1'b0;
    end else begin
      if_ack <= fin & ~own_dm;
      dm_ack <= fin & own_dm;
      if (fin) begin
        last_dm <= own_dm;
        if (!lat_we) begin
          if (own_dm) dm_rdata <= mem_rdata;
          else        if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (WAIT=1,2,3) on shared
// inputs, directed table, corner sequences and random traffic.
module tb_mem_port_arbiter;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] salt = '0;

  logic [31:0] o_if_rdata [N];
  logic [31:0] o_dm_rdata [N];
  logic [31:0] o_mem_addr [N];
  logic [31:0] o_mem_wdata[N];
  logic [31:0] m_rdata    [N];
  logic        o_if_ack   [N];
  logic        o_dm_ack   [N];
  logic        o_mem_en   [N];
  logic        o_mem_we   [N];
  logic        o_busy     [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : u
    assign m_rdata[g] = (o_mem_addr[g] == 32'h10) ? 32'h8C220004
                      : ((o_mem_addr[g] ^ 32'hFFFF0000) + salt);
    mem_port_arbiter #(.WAIT(g + 1), .AW(32), .DW(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (o_if_rdata[g]),
      .if_ack   (o_if_ack[g]),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_rdata (o_dm_rdata[g]),
      .dm_ack   (o_dm_ack[g]),
      .mem_en   (o_mem_en[g]),
      .mem_we   (o_mem_we[g]),
      .mem_addr (o_mem_addr[g]),
      .mem_wdata(o_mem_wdata[g]),
      .mem_rdata(m_rdata[g]),
      .busy     (o_busy[g])
    );
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference: a transaction is a grant cycle st; memory busy for
  // cycles st+1..st+W, ack in st+W+1, port free again after that.
  bit          m_act [N];
  int          m_st  [N];
  bit          m_dm  [N];
  bit          m_we  [N];
  bit          m_last[N];
  logic [31:0] m_addr[N];
  logic [31:0] m_wd  [N];
  logic [31:0] m_ifr [N];
  logic [31:0] m_dmr [N];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h10) ? 32'h8C220004 : ((a ^ 32'hFFFF0000) + salt);
  endfunction

  task automatic chk(input string nm, input int k,
                     input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", nm, k, cyc, a, e);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_act[k]  = 0;
      m_st[k]   = 0;
      m_dm[k]   = 0;
      m_we[k]   = 0;
      m_last[k] = 0;
      m_addr[k] = '0;
      m_wd[k]   = '0;
      m_ifr[k]  = '0;
      m_dmr[k]  = '0;
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < N; k++) begin
      int w;
      bit acc;
      bit done;
      w    = k + 1;
      acc  = m_act[k] && cyc >= m_st[k] + 1 && cyc <= m_st[k] + w;
      done = m_act[k] && cyc == m_st[k] + w + 1;
      chk("mem_en",    k, 32'(o_mem_en[k]), 32'(acc));
      chk("mem_we",    k, 32'(o_mem_we[k]), 32'(acc && m_we[k]));
      chk("busy",      k, 32'(o_busy[k]),   32'(m_act[k]));
      chk("mem_addr",  k, o_mem_addr[k],    m_addr[k]);
      chk("mem_wdata", k, o_mem_wdata[k],   m_wd[k]);
      chk("if_ack",    k, 32'(o_if_ack[k]), 32'(done && !m_dm[k]));
      chk("dm_ack",    k, 32'(o_dm_ack[k]), 32'(done && m_dm[k]));
      chk("if_rdata",  k, o_if_rdata[k],    m_ifr[k]);
      chk("dm_rdata",  k, o_dm_rdata[k],    m_dmr[k]);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < N; k++) begin
        int w;
        bit p;
        w = k + 1;
        if (m_act[k]) begin
          if (cyc == m_st[k] + w) begin
            if (!m_we[k]) begin
              if (m_dm[k]) m_dmr[k] = memf(m_addr[k]);
              else         m_ifr[k] = memf(m_addr[k]);
            end
            m_last[k] = m_dm[k];
          end
          if (cyc == m_st[k] + w + 1) m_act[k] = 0;
        end else if (if_req || dm_req) begin
          p         = dm_req && (!if_req || !m_last[k]);
          m_act[k]  = 1;
          m_st[k]   = cyc;
          m_dm[k]   = p;
          m_we[k]   = p && dm_we;
          m_addr[k] = p ? dm_addr : if_addr;
          m_wd[k]   = p ? dm_wdata : 32'h0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    model_step();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    bit          dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic run_txn(input int k, input vec_t v, output int lat,
                         output int en_c, output int we_c,
                         output int other_c, output bit addr_ok);
    lat = -1; en_c = 0; we_c = 0; other_c = 0; addr_ok = 1;
    if (v.dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (o_mem_en[k]) begin
        en_c++;
        if (o_mem_addr[k] !== v.addr) addr_ok = 0;
      end
      if (o_mem_we[k]) we_c++;
      if (v.dm ? o_if_ack[k] : o_dm_ack[k]) other_c++;
      if (v.dm ? o_dm_ack[k] : o_if_ack[k]) begin
        lat = n;
        break;
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
  endtask

  task automatic txn_check(input int k, input vec_t v);
    int lat, en_c, we_c, oth;
    bit aok;
    run_txn(k, v, lat, en_c, we_c, oth, aok);
    chk("txn_latency", k, lat, k + 2);
    chk("txn_en_cycles", k, en_c, k + 1);
    chk("txn_we_cycles", k, we_c, v.we ? k + 1 : 0);
    chk("txn_other_ack", k, oth, 0);
    chk("txn_addr", k, 32'(aok), 32'd1);
    chk("txn_rdata", k, v.dm ? o_dm_rdata[k] : o_if_rdata[k], v.exp_rd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tab[6];
    int   an[$];
    bit   ap[$];
    int   exp_n[4];
    bit   exp_p[4];
    int   cnt;

    tab[0] = '{0, 0, 32'h00000010, 32'h0,        32'h8C220004};
    tab[1] = '{1, 1, 32'h00000100, 32'hDEADBEEF, 32'h00000000};
    tab[2] = '{1, 0, 32'h00000100, 32'h0,        32'hFFFF0100};
    tab[3] = '{0, 0, 32'h00000020, 32'h0,        32'hFFFF0020};
    tab[4] = '{1, 1, 32'h00000200, 32'h12345678, 32'hFFFF0100};
    tab[5] = '{1, 0, 32'hFFFFFFFC, 32'h0,        32'h0000FFFC};

    do_reset();
    chk("rst_busy",     1, 32'(o_busy[1]),   32'd0);
    chk("rst_mem_en",   1, 32'(o_mem_en[1]), 32'd0);
    chk("rst_if_rdata", 1, o_if_rdata[1],    32'd0);
    chk("rst_dm_rdata", 1, o_dm_rdata[1],    32'd0);
    chk("rst_mem_addr", 1, o_mem_addr[1],    32'd0);

    foreach (tab[i]) txn_check(1, tab[i]);

    // conflict after reset, both held: DM, IF, DM, IF
    do_reset();
    exp_n = '{3, 7, 11, 15};
    exp_p = '{1, 0, 1, 0};
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (o_dm_ack[1]) begin an.push_back(n); ap.push_back(1); end
      if (o_if_ack[1]) begin an.push_back(n); ap.push_back(0); end
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("arb_ack_count", 1, an.size(), 4);
    for (int i = 0; i < 4 && i < an.size(); i++) begin
      chk("arb_ack_cycle", 1, an[i], exp_n[i]);
      chk("arb_ack_port", 1, 32'(ap[i]), 32'(exp_p[i]));
    end
    repeat (6) tick();

    // address change during access is ignored
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    tick();
    dm_addr = 32'h200;
    tick();
    chk("hold_en",   1, 32'(o_mem_en[1]), 32'd1);
    chk("hold_addr", 1, o_mem_addr[1],    32'h100);
    tick();
    chk("hold_ack",       1, 32'(o_dm_ack[1]), 32'd1);
    chk("hold_addr_done", 1, o_mem_addr[1],    32'h100);
    chk("hold_rdata",     1, o_dm_rdata[1],    32'hFFFF0100);
    dm_req = 1'b0;
    repeat (6) tick();

    // async reset in the 2nd access cycle of the WAIT=3 instance
    do_reset();
    if_req = 1'b1; if_addr = 32'h30;
    tick();
    tick();
    chk("pre_rst_en",   2, 32'(o_mem_en[2]), 32'd1);
    chk("pre_rst_busy", 2, 32'(o_busy[2]),   32'd1);
    #1;
    reset = 1'b1;
    if_req = 1'b0;
    model_reset();
    #1;
    chk("async_en",   2, 32'(o_mem_en[2]), 32'd0);
    chk("async_busy", 2, 32'(o_busy[2]),   32'd0);
    tick();
    reset = 1'b0;
    cnt = 0;
    repeat (6) begin
      tick();
      if (o_if_ack[2] || o_dm_ack[2]) cnt++;
    end
    chk("abort_no_ack", 2, cnt, 0);
    txn_check(2, '{0, 0, 32'h30, 32'h0, 32'hFFFF0030});
    repeat (6) tick();

    // WAIT=1 back-to-back fetches with if_req held
    an.delete();
    salt = 32'h0;
    if_req = 1'b1; if_addr = 32'h50;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (o_if_ack[0]) begin
        chk("b2b_rdata", 0, o_if_rdata[0], (32'h50 ^ 32'hFFFF0000) + salt);
        salt = salt + 32'h111;
        an.push_back(n);
      end
    end
    if_req = 1'b0;
    chk("b2b_count", 0, an.size(), 4);
    if (an.size() > 0) chk("b2b_first", 0, an[0], 2);
    for (int i = 1; i < an.size(); i++)
      chk("b2b_spacing", 0, an[i] - an[i-1], 3);
    repeat (6) tick();
    salt = 32'h0;

    // random traffic against the reference
    for (int i = 0; i < 400; i++) begin
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 79) == 0) begin
        reset = 1'b1;
        model_reset();
      end
      if_req   = ($urandom_range(0, 2) != 0);
      dm_req   = ($urandom_range(0, 2) != 0);
      dm_we    = 1'($urandom_range(0, 1));
      if_addr  = ($urandom_range(0, 3) == 0) ? 32'h10 : $urandom;
      dm_addr  = $urandom;
      dm_wdata = $urandom;
      if ($urandom_range(0, 15) == 0) salt = $urandom;
      tick();
      for (int k = 0; k < N; k++)
        chk("ack_excl", k, 32'(o_if_ack[k] & o_dm_ack[k]), 32'd0);
    end
    reset = 1'b0;
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
